// File: rtl/note_sequencer.sv
// Multi-track step recorder/player: records one-hot key codes into per-track step
// memories and plays masked tracks back together. Optional macro: SEQ_LOOP_EN (looped playback).
module note_sequencer #(
  parameter int NOTE_W     = 9,
  parameter int DEPTH      = 9,
  parameter int NUM_TRACKS = 2,
  localparam int TRK_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  step_tick,
  input  logic [NOTE_W-1:0]     note_in,
  input  logic                  rec_req,
  input  logic [TRK_W-1:0]      rec_track,
  input  logic [NUM_TRACKS-1:0] play_mask,
  input  logic                  play_start,
  input  logic                  play_stop,
  input  logic                  clear,
  output logic [NOTE_W-1:0]     note_out,
  output logic                  rec_busy,
  output logic                  play_busy,
  output logic                  rec_full,
  output logic [CNT_W-1:0]      step_idx
);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [NOTE_W-1:0] NOTE_ONE = NOTE_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

  state_t                  state_reg;
  logic [TRK_W-1:0]        trk_reg;
  logic [NUM_TRACKS-1:0]   mask_reg;
  logic [CNT_W-1:0]        len_reg [NUM_TRACKS];
  logic [CNT_W-1:0]        step_reg;
  logic [CNT_W-1:0]        maxlen_reg;
  logic [NOTE_W-1:0]       note_reg;
  logic [NOTE_W-1:0]       mem_reg [NUM_TRACKS][DEPTH];

  logic [NOTE_W-1:0]       nv;
  logic [NUM_TRACKS-1:0]   nonempty;
  logic [NOTE_W-1:0]       hit [NUM_TRACKS];
  logic [NOTE_W-1:0]       play_note;
  logic [CNT_W-1:0]        start_maxlen;
  logic [CNT_W-1:0]        rd_idx;
  logic [CNT_W-1:0]        rec_len;
  logic                    rec_room;
  logic                    step_in_range;
  logic                    wr_en;

  // Chords and glitches (more than one key) are recorded and monitored as rests.
  assign nv = ((note_in & (note_in - NOTE_ONE)) == '0) ? note_in : '0;

  assign step_in_range = (step_reg < maxlen_reg);
  // At end-of-sequence the read index falls back to step 0 so a looping tick can emit it.
  assign rd_idx        = step_in_range ? step_reg : '0;
  assign rec_len       = len_reg[trk_reg];
  assign rec_room      = (rec_len < DEPTH_C);
  assign wr_en         = (state_reg == S_REC) && !clear && rec_req && step_tick && rec_room;

  generate
    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_track
      assign nonempty[gi] = (len_reg[gi] != '0);
      assign hit[gi] = (mask_reg[gi] && (rd_idx < len_reg[gi])) ? mem_reg[gi][rd_idx] : '0;
    end
  endgenerate

  always_comb begin
    play_note    = '0;
    start_maxlen = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      play_note = play_note | hit[t];
      if (play_mask[t] && (len_reg[t] > start_maxlen)) start_maxlen = len_reg[t];
    end
  end

  // Step memory is never reset; len_reg alone decides what is readable.
  always_ff @(posedge clock) begin
    if (wr_en) mem_reg[trk_reg][rec_len] <= nv;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      trk_reg    <= '0;
      mask_reg   <= '0;
      step_reg   <= '0;
      maxlen_reg <= '0;
      note_reg   <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) len_reg[t] <= '0;
    end else if (clear) begin
      state_reg <= S_IDLE;
      note_reg  <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) len_reg[t] <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          note_reg <= nv;
          if (rec_req) begin
            state_reg          <= S_REC;
            trk_reg            <= rec_track;
            len_reg[rec_track] <= '0;
          end else if (play_start && ((play_mask & nonempty) != '0)) begin
            state_reg  <= S_PLAY;
            mask_reg   <= play_mask;
            step_reg   <= '0;
            maxlen_reg <= start_maxlen;
            note_reg   <= '0;
          end
        end
        S_REC: begin
          note_reg <= nv;
          if (!rec_req) state_reg <= S_IDLE;
          else if (step_tick && rec_room) len_reg[trk_reg] <= rec_len + CNT_ONE;
        end
        S_PLAY: begin
          if (play_stop) begin
            state_reg <= S_IDLE;
            note_reg  <= '0;
          end else if (step_tick) begin
            if (step_in_range) begin
              note_reg <= play_note;
              step_reg <= step_reg + CNT_ONE;
            end else begin
`ifdef SEQ_LOOP_EN
              note_reg <= play_note;
              step_reg <= CNT_ONE;
`else
              note_reg  <= '0;
              state_reg <= S_IDLE;
`endif
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign note_out  = note_reg;
  assign rec_busy  = (state_reg == S_REC);
  assign play_busy = (state_reg == S_PLAY);
  assign rec_full  = (state_reg == S_REC) && (rec_len == DEPTH_C);
  assign step_idx  = (state_reg == S_PLAY) ? step_reg : '0;

endmodule
